// File: rtl/ps2_voice_scheduler.sv
// Polyphonic PS/2 key to square-wave voice scheduler.
// Parses make/break codes, allocates voices, mixes and paces samples.
module ps2_voice_scheduler #(
  parameter int          NUM_VOICES = 4,
  parameter logic [31:0] AMPLITUDE  = 32'd10000000,
  parameter int          SAMPLE_DIV = 1042
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [7:0]            received_data,
  input  logic                  received_data_en,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic signed [31:0]    left_channel_audio_out,
  output logic signed [31:0]    right_channel_audio_out,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  voice_steal,
  output logic                  sample_overrun
);

  localparam int AW = $clog2(NUM_VOICES);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic signed [31:0] AMP = $signed(AMPLITUDE);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } pstate_t;

  typedef struct packed {
    logic [7:0]    code;
    logic [18:0]   hp;
    logic [18:0]   cnt;
    logic          phase;
    logic [AW-1:0] age;
  } voice_t;

  pstate_t state;
  pstate_t state_nxt;
  logic    make_ev;
  logic    brk_ev;

  voice_t voice [NUM_VOICES];

  logic [19:0] km;
  logic        km_valid;
  logic [18:0] km_hp;

  logic [NUM_VOICES-1:0] match;
  logic                  held;
  logic                  has_free;
  logic [AW-1:0]         free_idx;
  logic [AW-1:0]         old_idx;
  logic [AW-1:0]         old_age;
  logic [AW-1:0]         tgt;
  logic                  alloc;
  logic                  steal;
  logic                  clear;

  logic signed [31:0] mix;
  logic [DW-1:0]      div;
  logic               tick;
  logic               pending;
  logic               drain;

  // {valid, half-period}; unmapped codes return valid=0
  function automatic logic [19:0] keymap(input logic [7:0] code);
    case (code)
      8'h15:   keymap = {1'b1, 19'h2F691};
      8'h1D:   keymap = {1'b1, 19'h29AB2};
      8'h24:   keymap = {1'b1, 19'h24A26};
      8'h2D:   keymap = {1'b1, 19'h230E4};
      8'h2C:   keymap = {1'b1, 19'h1F240};
      8'h35:   keymap = {1'b1, 19'h1B6A4};
      8'h3C:   keymap = {1'b1, 19'h18CB7};
      8'h43:   keymap = {1'b1, 19'h17544};
      8'h44:   keymap = {1'b1, 19'h14C8B};
      8'h4D:   keymap = {1'b1, 19'h12843};
      8'h1E:   keymap = {1'b1, 19'h2C0A2};
      8'h26:   keymap = {1'b1, 19'h273C2};
      8'h2E:   keymap = {1'b1, 19'h20FE1};
      8'h36:   keymap = {1'b1, 19'h1D649};
      8'h3D:   keymap = {1'b1, 19'h1A2FA};
      8'h46:   keymap = {1'b1, 19'h16051};
      8'h45:   keymap = {1'b1, 19'h139E1};
      default: keymap = 20'h0;
    endcase
  endfunction

  assign km       = keymap(received_data);
  assign km_valid = km[19];
  assign km_hp    = km[18:0];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (received_data_en) begin
      unique case (state)
        IDLE: begin
          if (received_data == 8'hF0) begin
            state_nxt = BRK;
          end else if (received_data == 8'hE0) begin
            state_nxt = EXT;
          end else begin
            make_ev = 1'b1;
          end
        end
        BRK: begin
          brk_ev    = 1'b1;
          state_nxt = IDLE;
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
          end
        end
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Allocation: lowest free voice, else oldest (ties to lowest index)
  always_comb begin
    match    = '0;
    has_free = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = voice[0].age;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        has_free = 1'b1;
        free_idx = AW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_active[i] &&
          voice[i].code == received_data) begin
        match[i] = 1'b1;
      end
      if (i > 0 && voice[i].age > old_age) begin
        old_age = voice[i].age;
        old_idx = AW'(i);
      end
    end
  end

  assign held  = |match;
  assign alloc = make_ev & km_valid & ~held;
  assign steal = alloc & ~has_free;
  assign tgt   = has_free ? free_idx : old_idx;
  assign clear = brk_ev & km_valid;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      voice_active <= '0;
      voice_steal  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice[i] <= '0;
      end
    end else begin
      voice_steal <= steal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (alloc && tgt == AW'(i)) begin
          voice_active[i] <= 1'b1;
          voice[i].code   <= received_data;
          voice[i].hp     <= km_hp;
          voice[i].cnt    <= '0;
          voice[i].phase  <= 1'b1;
          voice[i].age    <= '0;
        end else if (voice_active[i]) begin
          if (voice[i].cnt == voice[i].hp) begin
            voice[i].cnt   <= '0;
            voice[i].phase <= ~voice[i].phase;
          end else begin
            voice[i].cnt <= voice[i].cnt + 1'b1;
          end
          if (alloc && voice[i].age != AGE_MAX) begin
            voice[i].age <= voice[i].age + 1'b1;
          end
          if (clear && match[i]) begin
            voice_active[i] <= 1'b0;
            voice[i].cnt    <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_active[i]) begin
        mix = voice[i].phase ? mix + AMP : mix - AMP;
      end
    end
  end

  assign tick  = (div == DIV_LAST);
  assign drain = pending & audio_out_allowed;

  // A tick landing on an undrained sample is merged and flagged
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div                     <= '0;
      pending                 <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      sample_overrun          <= 1'b0;
    end else begin
      div             <= tick ? '0 : div + 1'b1;
      pending         <= tick | (pending & ~audio_out_allowed);
      write_audio_out <= drain;
      if (drain) begin
        left_channel_audio_out  <= mix;
        right_channel_audio_out <= mix;
      end
      if (tick & pending & ~audio_out_allowed) begin
        sample_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Bench for ps2_voice_scheduler: timeline-based voice model,
// directed key sequences and a long randomized key/backpressure run.
module tb_ps2_voice_scheduler;

  localparam int NV  = 4;
  localparam int D   = 1042;
  localparam int AMP = 10000000;

  logic              clk     = 1'b0;
  logic              resetn  = 1'b0;
  logic [7:0]        data    = 8'h00;
  logic              en      = 1'b0;
  logic              allowed = 1'b1;
  logic              wr;
  logic signed [31:0] left;
  logic signed [31:0] right;
  logic [NV-1:0]     act;
  logic              steal;
  logic              ovr;

  ps2_voice_scheduler #(
    .NUM_VOICES(NV),
    .AMPLITUDE(32'd10000000),
    .SAMPLE_DIV(D)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .received_data(data),
    .received_data_en(en),
    .audio_out_allowed(allowed),
    .write_audio_out(wr),
    .left_channel_audio_out(left),
    .right_channel_audio_out(right),
    .voice_active(act),
    .voice_steal(steal),
    .sample_overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input longint got,
                     input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t",
                  name, got, want, $time);
  endtask

  // Model: voices as (code, half-period, alloc time, age)
  bit         m_act  [NV];
  logic [7:0] m_code [NV];
  int         m_hp   [NV];
  int         m_t0   [NV];
  int         m_age  [NV];
  int         r;
  bit         m_pend, m_ovr, m_wr, m_stl;
  int         m_ch;
  bit         m_brk, m_ext, m_xbrk;

  function automatic int hp_of(input logic [7:0] c);
    case (c)
      8'h15: return 'h2F691;
      8'h1D: return 'h29AB2;
      8'h24: return 'h24A26;
      8'h2D: return 'h230E4;
      8'h2C: return 'h1F240;
      8'h35: return 'h1B6A4;
      8'h3C: return 'h18CB7;
      8'h43: return 'h17544;
      8'h44: return 'h14C8B;
      8'h4D: return 'h12843;
      8'h1E: return 'h2C0A2;
      8'h26: return 'h273C2;
      8'h2E: return 'h20FE1;
      8'h36: return 'h1D649;
      8'h3D: return 'h1A2FA;
      8'h46: return 'h16051;
      8'h45: return 'h139E1;
      default: return -1;
    endcase
  endfunction

  // Phase from elapsed clocks since allocation: flips every hp+1
  function automatic int mix_now();
    int s = 0;
    for (int v = 0; v < NV; v++)
      if (m_act[v])
        s += (((r - 1 - m_t0[v]) / (m_hp[v] + 1)) % 2 == 0) ? AMP : -AMP;
    return s;
  endfunction

  function automatic logic [NV-1:0] pack_act();
    logic [NV-1:0] p = '0;
    for (int v = 0; v < NV; v++) p[v] = m_act[v];
    return p;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_code[v] = 0; m_hp[v] = 0;
      m_t0[v] = 0; m_age[v] = 0;
    end
    r = 0; m_pend = 0; m_ovr = 0; m_wr = 0; m_stl = 0; m_ch = 0;
    m_brk = 0; m_ext = 0; m_xbrk = 0;
  endtask

  task automatic do_make(input logic [7:0] b);
    int h = hp_of(b);
    int t = -1;
    if (h < 0) return;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_code[v] == b) return;
    for (int v = NV - 1; v >= 0; v--)
      if (!m_act[v]) t = v;
    if (t < 0) begin
      t = 0;
      for (int v = 1; v < NV; v++)
        if (m_age[v] > m_age[t]) t = v;
      m_stl = 1;
    end
    for (int v = 0; v < NV; v++)
      if (m_act[v] && v != t && m_age[v] < NV - 1) m_age[v]++;
    m_act[t] = 1; m_code[t] = b; m_hp[t] = h;
    m_t0[t] = r; m_age[t] = 0;
  endtask

  task automatic do_break(input logic [7:0] b);
    if (hp_of(b) < 0) return;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_code[v] == b) m_act[v] = 0;
  endtask

  task automatic handle_byte(input logic [7:0] b);
    if (m_brk) begin
      m_brk = 0; do_break(b);
    end else if (m_ext) begin
      m_ext = 0; m_xbrk = (b == 8'hF0);
    end else if (m_xbrk) begin
      m_xbrk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      do_make(b);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else begin
      m_wr = m_pend && allowed;
      if (m_wr) m_ch = mix_now();
      if ((r % D) == D - 1 && m_pend && !allowed) m_ovr = 1;
      m_pend = ((r % D) == D - 1) || (m_pend && !allowed);
      m_stl = 0;
      if (en) handle_byte(data);
      r++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("voice_active", act, pack_act());
      chk("voice_steal", steal, m_stl);
      chk("write_audio_out", wr, m_wr);
      chk("sample_overrun", ovr, m_ovr);
      chk("left", left, m_ch);
      chk("right", right, m_ch);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data = b; en = 1'b1;
    step(1);
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (allowed && $urandom_range(0, 399) == 0) allowed = 1'b0;
      else if (!allowed && $urandom_range(0, 59) == 0) allowed = 1'b1;
      step(1);
    end
  endtask

  task automatic wait_write(input int limit, output int waited);
    waited = 0;
    while (!wr && waited < limit) begin
      step(1);
      waited++;
    end
    chk("write_within_bound", wr, 1);
  endtask

  logic [7:0] mk_pool [5] = '{8'h15, 8'h1D, 8'h24, 8'h4D, 8'h1C};
  logic [7:0] br_pool [4] = '{8'h15, 8'h1D, 8'h24, 8'h1C};

  task automatic rand_event();
    int k = $urandom_range(0, 9);
    logic [7:0] m = mk_pool[$urandom_range(0, 4)];
    logic [7:0] b = br_pool[$urandom_range(0, 3)];
    if (k <= 3) begin
      send(m);
    end else if (k <= 6) begin
      send(8'hF0); idle($urandom_range(0, 2)); send(b);
    end else if (k == 7) begin
      send(8'hE0); idle($urandom_range(0, 2)); send(m);
    end else if (k == 8) begin
      send(8'hE0); send(8'hF0); idle($urandom_range(0, 2)); send(b);
    end else begin
      send(8'hF0); send(8'hF0);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  w;
  int  nw;
  time t_end;

  initial begin
    step(3);
    cmp_en = 1'b1;
    chk("reset act", act, 0);
    chk("reset write", wr, 0);
    chk("reset left", left, 0);
    chk("reset overrun", ovr, 0);
    resetn = 1'b1;
    step(2);

    send(8'h15); chk("act after 15", act, 4'b0001);
    send(8'h1D); chk("act after 1D", act, 4'b0011);
    send(8'h15); chk("held repeat", act, 4'b0011);
    chk("held no steal", steal, 0);
    wait_write(1100, w);
    chk("two voices sample", left, 20000000);
    step(1);
    wait_write(1100, w);
    chk("sample spacing", w + 1, 1042);
    send(8'hF0); send(8'h15);
    chk("break 15", act, 4'b0010);
    step(1);
    wait_write(1100, w);
    chk("one voice sample", left, 10000000);
    send(8'hF0); send(8'h1D);
    chk("all released", act, 4'b0000);

    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("four voices", act, 4'b1111);
    send(8'h2C);
    chk("steal pulse", steal, 1);
    chk("steal keeps full", act, 4'b1111);
    step(1);
    chk("steal one cycle", steal, 0);
    send(8'hF0); send(8'h15);
    chk("stolen code gone", act, 4'b1111);
    send(8'hF0); send(8'h2C);
    chk("voice0 held 2C", act, 4'b1110);
    send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h24);
    send(8'hF0); send(8'h2D);
    chk("cleared after steal", act, 4'b0000);

    send(8'hE0); send(8'h15);
    send(8'hE0); send(8'hF0); send(8'h15);
    chk("extended ignored", act, 4'b0000);
    send(8'hF0); send(8'hF0);
    send(8'h15);
    chk("parser back in idle", act, 4'b0001);
    send(8'hF0); send(8'h15);

    allowed = 1'b0;
    nw = 0;
    repeat (2500) begin
      step(1);
      nw += int'(wr);
    end
    chk("no writes while blocked", nw, 0);
    chk("overrun sticky", ovr, 1);
    allowed = 1'b1;
    step(1);
    chk("write after allow", wr, 1);

    send(8'h15); send(8'hF0);
    resetn = 1'b0;
    #1;
    chk("async reset act", act, 0);
    chk("async reset overrun", ovr, 0);
    chk("async reset left", left, 0);
    step(2);
    resetn = 1'b1;
    send(8'h15);
    chk("make after reset", act, 4'b0001);
    send(8'hF0); send(8'h15);

    send(8'h4D);
    t_end = $time + 64'd775000;
    while ($time < t_end) begin
      rand_event();
      idle($urandom_range(1, 300));
    end
    allowed = 1'b1;
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
